// File: rtl/score_ranker.sv
// Sorted top-5 best-time table: candidates are scanned one slot per cycle and
// inserted in ascending order, with a 1-deep pending buffer for overlapping triggers.
module score_ranker #(
  parameter logic [9:0] EMPTY_CODE = 10'h3FF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [9:0] new_score,
  output logic [9:0] top_score0,
  output logic [9:0] top_score1,
  output logic [9:0] top_score2,
  output logic [9:0] top_score3,
  output logic [9:0] top_score4,
  output logic [4:0] slot_valid,
  output logic       busy,
  output logic       rank_valid,
  output logic [2:0] last_rank,
  output logic       dropped
);

  typedef enum logic [1:0] {IDLE, SCAN, INSERT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d, pos_q, pos_d;
  logic [9:0]      cand_q, cand_d, pend_q, pend_d, prev_q;
  logic            pend_vld_q, pend_vld_d;
  logic [4:0][9:0] slot_q, slot_d, top_q, top_d;
  logic [4:0]      sv_q, sv_d, lowmask;
  logic            rank_valid_q, rank_valid_d, dropped_q, dropped_d;
  logic [2:0]      last_rank_q, last_rank_d;
  logic            trig, done;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pos_d        = pos_q;
    cand_d       = cand_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    slot_d       = slot_q;
    sv_d         = sv_q;
    rank_valid_d = 1'b0;
    last_rank_d  = last_rank_q;
    dropped_d    = dropped_q;
    done         = 1'b0;
    trig         = (new_score != 10'd0) && (new_score != prev_q);
    lowmask      = (5'd1 << pos_q) - 5'd1;

    case (state_q)
      IDLE: begin
        if (trig) begin
          cand_d  = new_score;
          idx_d   = 3'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!sv_q[idx_q] || (cand_q < slot_q[idx_q])) begin
          pos_d   = idx_q;
          state_d = INSERT;
        end else if (idx_q == 3'd4) begin
          rank_valid_d = 1'b1;
          last_rank_d  = 3'd7;
          done         = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      INSERT: begin
        // Shift-only insert; old slot 4 falls off the end.
        slot_d[0] = (pos_q == 3'd0) ? cand_q : slot_q[0];
        for (int i = 1; i < 5; i++) begin
          if (3'(i) == pos_q)     slot_d[i] = cand_q;
          else if (3'(i) > pos_q) slot_d[i] = slot_q[i-1];
        end
        sv_d         = ({sv_q[3:0], 1'b1} & ~lowmask) | (sv_q & lowmask);
        rank_valid_d = 1'b1;
        last_rank_d  = pos_q;
        done         = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Finishing a candidate: chain straight into pending (or a same-cycle trigger).
    if (done) begin
      idx_d = 3'd0;
      if (pend_vld_q) begin
        cand_d     = pend_q;
        pend_vld_d = 1'b0;
        state_d    = SCAN;
      end else if (trig) begin
        cand_d  = new_score;
        state_d = SCAN;
      end else begin
        state_d = IDLE;
      end
    end

    if (trig && (state_q != IDLE) && !(done && !pend_vld_q)) begin
      if (pend_vld_q && !done) begin
        dropped_d = 1'b1;
      end else begin
        pend_d     = new_score;
        pend_vld_d = 1'b1;
      end
    end

    for (int i = 0; i < 5; i++)
      top_d[i] = sv_d[i] ? slot_d[i] : EMPTY_CODE;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      pos_q        <= 3'd0;
      cand_q       <= 10'd0;
      pend_q       <= 10'd0;
      pend_vld_q   <= 1'b0;
      prev_q       <= 10'd0;
      slot_q       <= {5{EMPTY_CODE}};
      top_q        <= {5{EMPTY_CODE}};
      sv_q         <= 5'd0;
      rank_valid_q <= 1'b0;
      last_rank_q  <= 3'd7;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      cand_q       <= cand_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      prev_q       <= new_score;
      slot_q       <= slot_d;
      top_q        <= top_d;
      sv_q         <= sv_d;
      rank_valid_q <= rank_valid_d;
      last_rank_q  <= last_rank_d;
      dropped_q    <= dropped_d;
    end
  end

  assign top_score0 = top_q[0];
  assign top_score1 = top_q[1];
  assign top_score2 = top_q[2];
  assign top_score3 = top_q[3];
  assign top_score4 = top_q[4];
  assign slot_valid = sv_q;
  assign busy       = (state_q != IDLE);
  assign rank_valid = rank_valid_q;
  assign last_rank  = last_rank_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_score_ranker.sv
// Directed bench for score_ranker: a reference table model predicts rank and
// arrival cycle of every rank_valid pulse; a queue scoreboard checks them.
module tb_score_ranker;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic [9:0] new_score;
  logic [9:0] top_score0, top_score1, top_score2, top_score3, top_score4;
  logic [4:0] slot_valid;
  logic       busy, rank_valid, dropped;
  logic [2:0] last_rank;

  score_ranker dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .new_score(new_score),
    .top_score0(top_score0), .top_score1(top_score1), .top_score2(top_score2),
    .top_score3(top_score3), .top_score4(top_score4),
    .slot_valid(slot_valid), .busy(busy), .rank_valid(rank_valid),
    .last_rank(last_rank), .dropped(dropped)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct { int rank; int due; } exp_t;
  exp_t q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int mdl[5];
  int cnt = 0;
  logic [9:0] ts[5];

  assign ts[0] = top_score0;
  assign ts[1] = top_score1;
  assign ts[2] = top_score2;
  assign ts[3] = top_score3;
  assign ts[4] = top_score4;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Sorted-table reference: returns landing slot or 7 when not ranked.
  function automatic int model_ins(int v);
    int p;
    p = cnt;
    for (int i = 0; i < cnt; i++)
      if (v < mdl[i]) begin p = i; break; end
    if (p >= 5) return 7;
    for (int j = 4; j > p; j--) mdl[j] = mdl[j-1];
    mdl[p] = v;
    if (cnt < 5) cnt++;
    return p;
  endfunction

  always @(negedge clk_100MHz) begin
    exp_t e;
    if (rank_valid) begin
      pulses++;
      if (q.size() == 0) chk("rank_valid_expected", 0, 1);
      else begin
        e = q.pop_front();
        chk("last_rank", int'(last_rank), e.rank);
        chk("rank_latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic send(int v);
    exp_t e;
    @(negedge clk_100MHz);
    new_score = 10'(v);
    e.rank = model_ins(v);
    e.due  = cyc + 1 + ((e.rank == 7) ? 5 : 2 + e.rank);
    q.push_back(e);
    @(negedge clk_100MHz);
    new_score = 10'd0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk_100MHz);
      n++;
    end
    @(negedge clk_100MHz);
    chk("scoreboard_drained", q.size(), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic check_table();
    for (int i = 0; i < 5; i++)
      chk("top_score", int'(ts[i]), (i < cnt) ? mdl[i] : 'h3FF);
    chk("slot_valid", int'(slot_valid), (1 << cnt) - 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int t0, d50, dlast, busy_low, p0;

    reset = 1'b1;
    new_score = 10'd0;
    repeat (3) @(negedge clk_100MHz);
    check_table();
    chk("reset_last_rank", int'(last_rank), 7);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rank_valid", int'(rank_valid), 0);
    chk("reset_dropped", int'(dropped), 0);
    reset = 1'b0;

    send(125);
    wait_done();
    check_table();

    @(negedge clk_100MHz) reset = 1'b1;
    @(negedge clk_100MHz) reset = 1'b0;
    cnt = 0;

    send(90);  wait_done();
    send(40);  wait_done();
    send(200); wait_done();
    send(40);  wait_done();
    send(150); wait_done();
    send(300); wait_done();
    check_table();

    // Held level triggers exactly once.
    p0 = pulses;
    @(negedge clk_100MHz);
    new_score = 10'd77;
    e.rank = model_ins(77);
    e.due  = cyc + 1 + 2 + e.rank;
    q.push_back(e);
    repeat (20) @(negedge clk_100MHz);
    new_score = 10'd0;
    wait_done();
    chk("held_level_pulses", pulses - p0, 1);
    check_table();

    // Back-to-back: 50 scans, 60 goes pending, 70 is dropped.
    busy_low = 0;
    @(negedge clk_100MHz);
    new_score = 10'd50;
    t0 = cyc + 1;
    e.rank = model_ins(50);
    e.due  = t0 + 2 + e.rank;
    d50 = e.due;
    q.push_back(e);
    @(negedge clk_100MHz);
    if (!busy) busy_low++;
    new_score = 10'd60;
    e.rank = model_ins(60);
    e.due  = d50 + 2 + e.rank;
    dlast = e.due;
    q.push_back(e);
    @(negedge clk_100MHz);
    if (!busy) busy_low++;
    new_score = 10'd70;
    @(negedge clk_100MHz);
    if (!busy) busy_low++;
    new_score = 10'd0;
    while (cyc < dlast) begin
      @(negedge clk_100MHz);
      if (cyc < dlast && !busy) busy_low++;
    end
    chk("busy_continuous", busy_low, 0);
    wait_done();
    chk("dropped_sticky", int'(dropped), 1);
    check_table();

    // Reset mid-scan of a full table: no insert, no pulse.
    p0 = pulses;
    @(negedge clk_100MHz) new_score = 10'd500;
    @(negedge clk_100MHz) new_score = 10'd0;
    @(negedge clk_100MHz) reset = 1'b1;
    @(negedge clk_100MHz);
    cnt = 0;
    check_table();
    chk("midscan_reset_busy", int'(busy), 0);
    chk("midscan_reset_last_rank", int'(last_rank), 7);
    chk("midscan_reset_dropped", int'(dropped), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_100MHz);
    chk("midscan_reset_no_pulse", pulses - p0, 0);
    check_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
